// File: rtl/parc_core_reorder_buffer_pkg.sv
// Shared PARC core constants: ROB geometry, bypass-mux source code for the ROB,
// and functional-unit codes used by issue/decode.
package parc_core_reorder_buffer_pkg;

  localparam int ROB_ENTRIES = 16;
  localparam int ROB_SLOT_W  = 4;

  localparam logic [2:0] BYP_SEL_ROB = 3'd5;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_ALU  = 2'd1,
    FU_MEM  = 2'd2,
    FU_MUL  = 2'd3
  } fu_code_e;

  typedef logic [ROB_SLOT_W-1:0] rob_slot_t;

endpackage

// File: rtl/parc_core_reorder_buffer.sv
// Reorder buffer: allocates slots in program order, accepts out-of-order
// writeback, and retires one completed entry per cycle in order.
module parc_core_reorder_buffer
  import parc_core_reorder_buffer_pkg::*;
#(
  parameter int ENTRIES = ROB_ENTRIES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rob_alloc_req_val,
  output logic            rob_alloc_req_rdy,
  input  logic [4:0]      rob_alloc_req_preg,
  output logic [3:0]      rob_alloc_resp_slot,
  input  logic            rob_fill_val,
  input  logic [3:0]      rob_fill_slot,
  input  logic [31:0]     rob_fill_data,
  input  logic [3:0]      rob_rd0_slot,
  input  logic [3:0]      rob_rd1_slot,
  output logic [31:0]     rob_rd0_data,
  output logic [31:0]     rob_rd1_data,
  output logic            rob_commit_wen,
  output logic [3:0]      rob_commit_slot,
  output logic [4:0]      rob_commit_rf_waddr,
  output logic [31:0]     rob_commit_data,
  output logic            rob_empty
);

  localparam logic [ROB_SLOT_W:0] FULL_COUNT = (ROB_SLOT_W+1)'(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] pending;
  logic [4:0]         preg [ENTRIES];
  logic [31:0]        data [ENTRIES];

  rob_slot_t           head;
  rob_slot_t           tail;
  logic [ROB_SLOT_W:0] count;

  logic alloc_fire;
  logic commit_fire;
  logic fill_hit;

  // Ready depends only on registered occupancy, so a retiring entry never
  // frees space for an allocation in the same cycle.
  assign rob_alloc_req_rdy   = (count != FULL_COUNT);
  assign rob_alloc_resp_slot = tail;
  assign alloc_fire          = rob_alloc_req_val && rob_alloc_req_rdy;
  assign fill_hit            = rob_fill_val && valid[rob_fill_slot];
  assign commit_fire         = valid[head] && !pending[head];

  assign rob_commit_wen      = commit_fire;
  assign rob_commit_slot     = head;
  assign rob_commit_rf_waddr = preg[head];
  assign rob_commit_data     = data[head];
  assign rob_empty           = (count == '0);

  assign rob_rd0_data = data[rob_rd0_slot];
  assign rob_rd1_data = data[rob_rd1_slot];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid   <= '0;
      pending <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (fill_hit)
        pending[rob_fill_slot] <= 1'b0;
      if (commit_fire) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (alloc_fire) begin
        valid[tail]   <= 1'b1;
        pending[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is deliberately left out of reset; it only matters
  // while the owning slot is valid.
  always_ff @(posedge clk) begin
    if (alloc_fire)
      preg[tail] <= rob_alloc_req_preg;
    if (fill_hit)
      data[rob_fill_slot] <= rob_fill_data;
  end

endmodule

// File: tb/tb_parc_core_reorder_buffer.sv
// Self-checking bench for parc_core_reorder_buffer: directed scenarios with
// literal expectations plus randomized traffic checked against a queue model.
module tb_parc_core_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rob_alloc_req_val = 1'b0;
  logic        rob_alloc_req_rdy;
  logic [4:0]  rob_alloc_req_preg = '0;
  logic [3:0]  rob_alloc_resp_slot;
  logic        rob_fill_val = 1'b0;
  logic [3:0]  rob_fill_slot = '0;
  logic [31:0] rob_fill_data = '0;
  logic [3:0]  rob_rd0_slot = '0;
  logic [3:0]  rob_rd1_slot = '0;
  logic [31:0] rob_rd0_data;
  logic [31:0] rob_rd1_data;
  logic        rob_commit_wen;
  logic [3:0]  rob_commit_slot;
  logic [4:0]  rob_commit_rf_waddr;
  logic [31:0] rob_commit_data;
  logic        rob_empty;

  int checks = 0;
  int fails  = 0;

  parc_core_reorder_buffer dut (
    .clk                 (clk),
    .reset               (reset),
    .rob_alloc_req_val   (rob_alloc_req_val),
    .rob_alloc_req_rdy   (rob_alloc_req_rdy),
    .rob_alloc_req_preg  (rob_alloc_req_preg),
    .rob_alloc_resp_slot (rob_alloc_resp_slot),
    .rob_fill_val        (rob_fill_val),
    .rob_fill_slot       (rob_fill_slot),
    .rob_fill_data       (rob_fill_data),
    .rob_rd0_slot        (rob_rd0_slot),
    .rob_rd1_slot        (rob_rd1_slot),
    .rob_rd0_data        (rob_rd0_data),
    .rob_rd1_data        (rob_rd1_data),
    .rob_commit_wen      (rob_commit_wen),
    .rob_commit_slot     (rob_commit_slot),
    .rob_commit_rf_waddr (rob_commit_rf_waddr),
    .rob_commit_data     (rob_commit_data),
    .rob_empty           (rob_empty)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the ROB is an ordered list of in-flight instructions.
  typedef struct {
    int          slot;
    int          preg;
    bit          filled;
    logic [31:0] data;
  } ent_t;

  ent_t        rob_q[$];
  int          mtail = 0;
  logic [31:0] mdata [16];
  bit          mknown [16];

  function automatic int find_slot(input int slot);
    for (int i = 0; i < rob_q.size(); i++)
      if (rob_q[i].slot == slot) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rob_q.delete();
      mtail = 0;
    end else begin : model_step
      bit   do_commit;
      bit   can_alloc;
      int   idx;
      ent_t e;
      do_commit = (rob_q.size() > 0) && rob_q[0].filled;
      can_alloc = rob_q.size() < 16;
      if (rob_fill_val) begin
        idx = find_slot(int'(rob_fill_slot));
        if (idx >= 0) begin
          rob_q[idx].filled = 1'b1;
          rob_q[idx].data   = rob_fill_data;
          mdata[rob_fill_slot]  = rob_fill_data;
          mknown[rob_fill_slot] = 1'b1;
        end
      end
      if (do_commit) void'(rob_q.pop_front());
      if (rob_alloc_req_val && can_alloc) begin
        e.slot   = mtail;
        e.preg   = int'(rob_alloc_req_preg);
        e.filled = 1'b0;
        e.data   = '0;
        rob_q.push_back(e);
        mtail = (mtail + 1) % 16;
      end
    end
  end

  always @(negedge clk) begin : compare
    int n;
    int head_slot;
    bit exp_wen;
    n         = rob_q.size();
    head_slot = (n > 0) ? rob_q[0].slot : mtail;
    exp_wen   = (n > 0) && rob_q[0].filled;
    check_output("model_rdy", 32'(rob_alloc_req_rdy), 32'(n < 16));
    check_output("model_resp_slot", 32'(rob_alloc_resp_slot), 32'(mtail));
    check_output("model_empty", 32'(rob_empty), 32'(n == 0));
    check_output("model_commit_wen", 32'(rob_commit_wen), 32'(exp_wen));
    check_output("model_commit_slot", 32'(rob_commit_slot), 32'(head_slot));
    if (exp_wen) begin
      check_output("model_commit_waddr", 32'(rob_commit_rf_waddr), 32'(rob_q[0].preg));
      check_output("model_commit_data", rob_commit_data, rob_q[0].data);
    end
    if (mknown[rob_rd0_slot]) check_output("model_rd0", rob_rd0_data, mdata[rob_rd0_slot]);
    if (mknown[rob_rd1_slot]) check_output("model_rd1", rob_rd1_data, mdata[rob_rd1_slot]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit av, input int preg, input bit fv, input int fslot,
                                input logic [31:0] fdata);
    rob_alloc_req_val  = av;
    rob_alloc_req_preg = 5'(preg);
    rob_fill_val       = fv;
    rob_fill_slot      = 4'(fslot);
    rob_fill_data      = fdata;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 0, 1'b0, 0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    check_output("rst_rdy", 32'(rob_alloc_req_rdy), 32'd1);
    check_output("rst_resp_slot", 32'(rob_alloc_resp_slot), 32'd0);
    check_output("rst_commit_wen", 32'(rob_commit_wen), 32'd0);
    check_output("rst_empty", 32'(rob_empty), 32'd1);
    check_output("rst_commit_slot", 32'(rob_commit_slot), 32'd0);
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    // Basic alloc -> fill -> commit
    do_reset();
    apply_stimulus(1'b1, 3, 1'b0, 0, 32'h0);
    #1 check_output("basic_resp_slot", 32'(rob_alloc_resp_slot), 32'd0);
    step();
    apply_stimulus(1'b0, 0, 1'b1, 0, 32'hDEADBEEF);
    #1 check_output("basic_no_early_commit", 32'(rob_commit_wen), 32'd0);
    step();
    idle();
    #1;
    check_output("basic_commit_wen", 32'(rob_commit_wen), 32'd1);
    check_output("basic_commit_slot", 32'(rob_commit_slot), 32'd0);
    check_output("basic_commit_waddr", 32'(rob_commit_rf_waddr), 32'd3);
    check_output("basic_commit_data", rob_commit_data, 32'hDEADBEEF);
    step();
    check_output("basic_empty_after", 32'(rob_empty), 32'd1);

    // Fill to capacity, then retire one entry
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, i, 1'b0, 0, 32'h0);
      #1;
      check_output("full_resp_slot", 32'(rob_alloc_resp_slot), 32'(i));
      check_output("full_rdy_pre", 32'(rob_alloc_req_rdy), 32'd1);
      step();
    end
    apply_stimulus(1'b1, 9, 1'b0, 0, 32'h0);
    #1 check_output("full_rdy_low", 32'(rob_alloc_req_rdy), 32'd0);
    step();
    apply_stimulus(1'b0, 0, 1'b1, 0, 32'h00000100);
    step();
    idle();
    #1;
    check_output("full_commit_wen", 32'(rob_commit_wen), 32'd1);
    check_output("full_rdy_during_commit", 32'(rob_alloc_req_rdy), 32'd0);
    step();
    check_output("full_rdy_after_commit", 32'(rob_alloc_req_rdy), 32'd1);

    // Out-of-order writeback retires in order
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 10 + i, 1'b0, 0, 32'h0);
      step();
    end
    for (int s = 2; s >= 0; s--) begin
      apply_stimulus(1'b0, 0, 1'b1, s, 32'hA0 + 32'(s));
      #1 check_output("ooo_no_commit_yet", 32'(rob_commit_wen), 32'd0);
      step();
    end
    idle();
    for (int s = 0; s < 3; s++) begin
      #1;
      check_output("ooo_commit_wen", 32'(rob_commit_wen), 32'd1);
      check_output("ooo_commit_slot", 32'(rob_commit_slot), 32'(s));
      check_output("ooo_commit_data", rob_commit_data, 32'hA0 + 32'(s));
      step();
    end
    check_output("ooo_empty", 32'(rob_empty), 32'd1);

    // Pointer wrap over 20 single-entry lifetimes
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, i % 32, 1'b0, 0, 32'h0);
      #1 check_output("wrap_resp_slot", 32'(rob_alloc_resp_slot), 32'(i % 16));
      step();
      apply_stimulus(1'b0, 0, 1'b1, i % 16, 32'(i) * 32'h1111);
      step();
      idle();
      #1;
      check_output("wrap_commit_slot", 32'(rob_commit_slot), 32'(i % 16));
      check_output("wrap_commit_wen", 32'(rob_commit_wen), 32'd1);
      step();
    end

    // Bypass reads come from storage only
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, i, 1'b0, 0, 32'h0);
      step();
    end
    rob_rd0_slot = 4'd5;
    rob_rd1_slot = 4'd5;
    apply_stimulus(1'b0, 0, 1'b1, 5, 32'hAAAA5555);
    step();
    apply_stimulus(1'b0, 0, 1'b1, 5, 32'h12345678);
    #1;
    check_output("byp_rd0_old", rob_rd0_data, 32'hAAAA5555);
    check_output("byp_rd1_old", rob_rd1_data, 32'hAAAA5555);
    step();
    idle();
    #1;
    check_output("byp_rd0_new", rob_rd0_data, 32'h12345678);
    check_output("byp_rd1_new", rob_rd1_data, 32'h12345678);

    // Asynchronous reset with entries in flight
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, i + 1, 1'b0, 0, 32'h0);
      step();
    end
    for (int s = 1; s <= 4; s++) begin
      apply_stimulus(1'b0, 0, 1'b1, s, 32'h500 + 32'(s));
      step();
    end
    idle();
    #1;
    check_output("midrst_busy_empty", 32'(rob_empty), 32'd0);
    check_output("midrst_busy_wen", 32'(rob_commit_wen), 32'd0);
    reset = 1'b1;
    #1;
    check_output("midrst_wen", 32'(rob_commit_wen), 32'd0);
    check_output("midrst_rdy", 32'(rob_alloc_req_rdy), 32'd1);
    check_output("midrst_empty", 32'(rob_empty), 32'd1);
    check_output("midrst_commit_slot", 32'(rob_commit_slot), 32'd0);
    check_output("midrst_resp_slot", 32'(rob_alloc_resp_slot), 32'd0);
    step();
    reset = 1'b0;

    // Randomized traffic in phases of differing alloc/fill pressure
    do_reset();
    for (int phase = 0; phase < 6; phase++) begin
      for (int c = 0; c < 500; c++) begin : rand_cycle
        int   unfilled[$];
        bit   av;
        bit   fv;
        int   fslot;
        av = ($urandom_range(0, 99) < ((phase % 2 == 0) ? 80 : 30));
        fv = ($urandom_range(0, 99) < ((phase % 2 == 0) ? 25 : 85));
        unfilled.delete();
        foreach (rob_q[k]) if (!rob_q[k].filled) unfilled.push_back(rob_q[k].slot);
        if (unfilled.size() > 0 && $urandom_range(0, 9) < 8)
          fslot = unfilled[$urandom_range(0, unfilled.size() - 1)];
        else
          fslot = int'($urandom_range(0, 15));
        apply_stimulus(av, int'($urandom_range(0, 31)), fv, fslot, $urandom());
        rob_rd0_slot = 4'($urandom_range(0, 15));
        rob_rd1_slot = 4'($urandom_range(0, 15));
        step();
      end
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/parc_core_reorder_buffer.md
PARC_CORE_REORDER_BUFFER -- requirements
Module: parc_core_reorder_buffer

Interface
REQ-001 SHALL have parameter: ENTRIES, 16, number of ROB slots; slot index width fixed at 4 bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: rob_alloc_req_val  input  1  decode requests a slot for an accepted dst-writing instruction.
REQ-005 SHALL have port: rob_alloc_req_rdy  output  1  ROB can accept an allocation this cycle.
REQ-006 SHALL have port: rob_alloc_req_preg  input  5  architectural destination register.
REQ-007 SHALL have port: rob_alloc_resp_slot  output  4  slot granted; feeds the scoreboard's rob_alloc_slot.
REQ-008 SHALL have ports: rob_fill_val  input  1; rob_fill_slot  input  4; rob_fill_data  input  32; writeback result into a slot.
REQ-009 SHALL have ports: rob_rd0_slot, rob_rd1_slot  input  4; rob_rd0_data, rob_rd1_data  output  32; operand bypass read (byp mux sel 5).
REQ-010 SHALL have ports: rob_commit_wen  output  1; rob_commit_slot  output  4; rob_commit_rf_waddr  output  5; rob_commit_data  output  32; in-order retirement to register file and scoreboard.
REQ-011 SHALL have port: rob_empty  output  1  no valid entries; used for drain/halt.

Function
REQ-012 SHALL hold per slot: valid, pending, preg[4:0], data[31:0]; plus head (commit) pointer, tail (alloc) pointer, count 0..16.
REQ-013 SHALL drive rob_alloc_req_rdy = (count != 16), from registered state only; commit in the same cycle does NOT make a full ROB ready.
REQ-014 SHALL drive rob_alloc_resp_slot = tail combinationally, valid in the cycle of the request.
REQ-015 SHALL on alloc fire (val && rdy): slot[tail].valid=1, pending=1, preg captured; tail = tail+1 mod 16.
REQ-016 SHALL on rob_fill_val: slot[fill_slot].data=fill_data, pending=0; fill to an invalid slot is ignored (no state change).
REQ-017 SHALL assert rob_commit_wen combinationally when slot[head].valid && !slot[head].pending, with commit_slot=head, rf_waddr=slot[head].preg, data=slot[head].data.
REQ-018 SHALL on commit: slot[head].valid=0, head = head+1 mod 16; at most one commit per cycle.
REQ-019 SHALL update count +1 on alloc only, -1 on commit only, unchanged on both or neither.
REQ-020 SHALL give commit priority over nothing: fill and commit use registered state, so a slot filled in cycle N commits no earlier than N+1.
REQ-021 SHALL return rob_rdN_data = slot[rdN_slot].data from registered storage; no same-cycle fill forwarding.
REQ-022 SHALL allow alloc, fill and commit in the same cycle on distinct slots; alloc on slot being committed cannot occur (full excluded by REQ-013).
REQ-023 SHALL treat preg 0 like any register; register file ignores writes to r0.
REQ-024 SHALL wrap head and tail from 15 to 0 without gap.

Reset
REQ-025 SHALL on reset clear all valid and pending bits, head=tail=0, count=0, immediately (asynchronous), including mid-operation.
REQ-026 SHALL present after reset: rob_alloc_req_rdy=1, rob_alloc_resp_slot=0, rob_commit_wen=0, rob_empty=1, rob_commit_slot=0.
REQ-027 SHALL NOT reset data/preg storage; their values are meaningful only for valid slots.

Structure
REQ-028 SHALL place ROB entry count, slot width, bypass-mux code 5 (ROB source) and functional-unit codes (ALU 1, MEM 2, MUL 3) in the shared PARC core package.
REQ-029 SHALL be a single module with flat slot arrays; no sub-module is natural.

Verification
REQ-030 SHALL test: after reset, alloc preg 3, fill slot 0 data 0xDEADBEEF next cycle -> commit_wen one cycle later with slot 0, waddr 3, data 0xDEADBEEF; rob_empty=1 after.
REQ-031 SHALL test: 16 back-to-back allocs, no fills -> slots 0..15 granted, rdy=0 on 17th cycle; fill slot 0, commit -> rdy=1 the following cycle.
REQ-032 SHALL test out-of-order fill: alloc slots 0,1,2; fill 2 then 1 then 0 -> commits occur in order 0,1,2 on consecutive cycles after slot 0 fill.
REQ-033 SHALL test wrap: 20 alloc/fill/commit sequences -> slot 15 followed by slot 0, count never exceeds 16.
REQ-034 SHALL test bypass: fill slot 5 with 0x12345678 -> rob_rd0_data and rob_rd1_data with slot 5 read 0x12345678 from next cycle; same-cycle read returns old data.
REQ-035 SHALL test reset mid-operation: 7 entries valid, 3 pending, reset asserted -> commit_wen=0, rdy=1, empty=1 without waiting for a clock edge.
